mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register. It drives a variable-latency data-memory bus with a req/ready handshake and stalls the pipeline while an access is outstanding. It formats load data with byte/half extraction and sign or zero extension, and forwards the result, address and write-back controls toward write-back.

Parameters:
TIMEOUT_CYCLES, 16, maximum BUSY cycles waiting for dmem_ready before a bus error is declared (range 1..255)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
valid_i  input  1  EX/MEM holds a live instruction
MemRead_i  input  1  load
MemWrite_i  input  1  store
funct3_i  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
memAddress_i  input  32  ALU result / effective address
writeData_i  input  32  store data (rs2)
rd_i  input  5  destination register
RegWrite_i  input  1  write-back enable
MemtoReg_i  input  2  write-back select
dmem_req  output  1  bus request, held until ready
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ready  input  1  access complete this cycle; dmem_rdata valid when high
dmem_rdata  input  32  read word
readData_o  output  32  formatted load data to MEM/WB
memAddress_o  output  32  memAddress_i passthrough
rd_o  output  5  rd_i passthrough
RegWrite_o  output  1  RegWrite_i gated by errors
MemtoReg_o  output  2  passthrough
stall_o  output  1  hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not capture
misalign_err_o  output  1  one-cycle flag, misaligned access
bus_err_o  output  1  one-cycle flag, timeout

Behaviour:
- The "Already decided" constraint: one clock, clk; reset rstn is asynchronous and active-low.
- Reset: state IDLE, timeout counter 0. dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be and the load-data register all 0. stall_o, misalign_err_o and bus_err_o are forced 0 while rstn is low. Reset mid-access aborts immediately: dmem_req drops asynchronously and no retry occurs.
- memop = valid_i & (MemRead_i | MemWrite_i). Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- States:
  - IDLE
    - No memop: stall_o=0; passthrough in the same cycle (0 added latency).
    - memop and misaligned: no bus access; misalign_err_o=1; RegWrite_o=0; stall_o=0.
    - memop and aligned: stall_o=1. Latch dmem_addr, dmem_we, dmem_be, dmem_wdata and funct3/byte offset. Go to BUSY; dmem_req=1 from the next cycle.
  - BUSY
    - stall_o=1; dmem_req=1; the counter increments each cycle.
    - dmem_ready=1: capture dmem_rdata (loads); dmem_req drops next edge; go to DONE.
    - Counter reaches TIMEOUT_CYCLES with no ready: go to DONE with the error bit set.
    - dmem_ready on the same cycle as the counter reaching TIMEOUT_CYCLES: ready wins, no error.
  - DONE
    - stall_o=0; readData_o is formatted from the latched word. MEM/WB captures at this edge; go to IDLE.
    - With the error bit set: bus_err_o=1, readData_o=0, RegWrite_o=0.
    - The next instruction is evaluated in IDLE next cycle; a memop is never re-issued from DONE.
- Latency: aligned access with ready in the first BUSY cycle gives stall_o high 2 cycles; the instruction spends 3 cycles in MEM.
- Upstream holds all *_i stable while stall_o=1.
- Store formatting:
  - SB: wdata={4{b}}, be=0001<<addr[1:0].
  - SH: wdata={2{h}}, be=0011<<addr[1:0].
  - SW: be=1111.
- Load formatting: select the byte/half by latched offset. funct3 000/001 sign-extend; 100/101 zero-extend; 010 full word. Any other funct3 on a load is treated as W.
- readData_o is don't-care for non-loads; the bench checks only RegWrite_o/MemtoReg_o in that case.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, BUSY, DONE}, and the misalign function.
- Sub-module lsu_load_align: combinational word + offset + funct3 -> 32-bit extended result.
- Store lane/byte-enable generation stays inline.

Test Plan:
- Non-memory ALU op, memAddress_i=0x0000_1234, rd_i=5, RegWrite_i=1 -> same-cycle passthrough, stall_o=0, dmem_req never asserted.
- LB addr=0x103, ready on first BUSY cycle, rdata=0x80FF_1234 -> stall_o 2 cycles, dmem_addr=0x100, readData_o=0xFFFF_FF80.
- LHU addr=0x202, ready after 3 BUSY cycles, rdata=0xBEEF_0000 -> stall_o 4 cycles, readData_o=0x0000_BEEF.
- SB addr=0x301, writeData=0x0000_00AB -> dmem_we=1, be=0010, wdata=0xABAB_ABAB, req held until ready.
- LW addr=0x402 -> misalign_err_o pulse, no dmem_req, stall_o=0, RegWrite_o=0.
- LW with no ready for TIMEOUT_CYCLES=16 -> bus_err_o pulse in DONE, readData_o=0, RegWrite_o=0. Separately, rstn low during BUSY -> dmem_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Unlisted funct3 codes are handled as word accesses, so they need word alignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr_lo[0];
            default:     return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatting: picks the byte/half addressed by the latched offset and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            F3_W:    data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one data-memory access per memop and stalls the pipe until it completes.
//   state | meaning
//   IDLE  | evaluate EX/MEM; pass non-memops through, flag misaligned ones, launch aligned ones
//   BUSY  | request held on the bus, waiting for dmem_ready or the timeout
//   DONE  | result (or bus error) presented to MEM/WB for one cycle
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] memAddress_i,
    input  logic [31:0] writeData_i,
    input  logic [4:0]  rd_i,
    input  logic        RegWrite_i,
    input  logic [1:0]  MemtoReg_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] readData_o,
    output logic [31:0] memAddress_o,
    output logic [4:0]  rd_o,
    output logic        RegWrite_o,
    output logic [1:0]  MemtoReg_o,
    output logic        stall_o,
    output logic        misalign_err_o,
    output logic        bus_err_o
);

    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] rdata_q, rdata_d;

    logic        memop, misaligned, issue;
    logic [31:0] wdata_new, load_data;
    logic [3:0]  be_new;

    assign memop      = valid_i & (MemRead_i | MemWrite_i);
    assign misaligned = is_misaligned(funct3_i, memAddress_i[1:0]);
    assign issue      = (state_q == IDLE) & memop & ~misaligned;

    always_comb begin
        wdata_new = writeData_i;
        be_new    = 4'b1111;
        case (funct3_i)
            F3_B, F3_BU: begin
                wdata_new = {4{writeData_i[7:0]}};
                be_new    = 4'b0001 << memAddress_i[1:0];
            end
            F3_H, F3_HU: begin
                wdata_new = {2{writeData_i[15:0]}};
                be_new    = 4'b0011 << memAddress_i[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d  = BUSY;
                    cnt_d    = 8'd0;
                    err_d    = 1'b0;
                    req_d    = 1'b1;
                    we_d     = MemWrite_i;
                    addr_d   = {memAddress_i[31:2], 2'b00};
                    wdata_d  = wdata_new;
                    be_d     = be_new;
                    funct3_d = funct3_i;
                    offset_d = memAddress_i[1:0];
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // A ready arriving on the final allowed cycle still completes cleanly.
                if (dmem_ready) begin
                    if (!we_q) rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_d == TIMEOUT_TC) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            funct3_q <= 3'd0;
            offset_q <= 2'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            rdata_q  <= rdata_d;
        end
    end

    lsu_load_align u_load_align (
        .word_i   (rdata_q),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign memAddress_o   = memAddress_i;
    assign rd_o           = rd_i;
    assign MemtoReg_o     = MemtoReg_i;
    assign readData_o     = ((state_q == DONE) && err_q) ? 32'd0 : load_data;
    assign RegWrite_o     = RegWrite_i & ~((state_q == IDLE) & memop & misaligned)
                                       & ~((state_q == DONE) & err_q);
    assign stall_o        = rstn & (issue | (state_q == BUSY));
    assign misalign_err_o = rstn & (state_q == IDLE) & memop & misaligned;
    assign bus_err_o      = rstn & (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: passthrough, loads/stores, misalignment, timeout, reset abort.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i, MemRead_i, MemWrite_i, RegWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] memAddress_i, writeData_i;
    logic [4:0]  rd_i;
    logic [1:0]  MemtoReg_i;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] readData_o, memAddress_o;
    logic [4:0]  rd_o;
    logic        RegWrite_o, stall_o, misalign_err_o, bus_err_o;
    logic [1:0]  MemtoReg_o;

    int checks = 0;
    int errors = 0;
    int stall_total = 0;
    int req_total = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .memAddress_i(memAddress_i),
        .writeData_i(writeData_i), .rd_i(rd_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .readData_o(readData_o),
        .memAddress_o(memAddress_o), .rd_o(rd_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .stall_o(stall_o), .misalign_err_o(misalign_err_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stall_o === 1'b1)  stall_total <= stall_total + 1;
        if (dmem_req === 1'b1) req_total   <= req_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = 3'd0;
        memAddress_i = 32'd0; writeData_i = 32'd0; rd_i = 5'd0; RegWrite_i = 1'b0;
        MemtoReg_i = 2'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    endtask

    // ready is raised in BUSY cycle number `waits`
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rd);
        int s0;
        step();
        s0 = stall_total;
        valid_i = 1'b1; MemRead_i = !we; MemWrite_i = we; funct3_i = f3;
        memAddress_i = addr; writeData_i = wdata; rd_i = 5'd9; RegWrite_i = !we;
        MemtoReg_i = we ? 2'd0 : 2'd1; dmem_ready = 1'b0;
        #1;
        check({tag, "_issue_stall"}, 32'(stall_o), 32'd1);
        check({tag, "_issue_req"}, 32'(dmem_req), 32'd0);
        for (int i = 1; i <= waits; i++) begin
            step();
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 32'h5A5A_5A5A;
            #1;
            check({tag, "_busy_req"}, 32'(dmem_req), 32'd1);
            if (i == 1) begin
                check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                check({tag, "_we"}, 32'(dmem_we), 32'(we));
                check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
                check({tag, "_wdata"}, dmem_wdata, exp_wdata);
            end
        end
        step();
        dmem_ready = 1'b0;
        #1;
        check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_done_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_stall_cycles"}, 32'(stall_total - s0), 32'(waits + 1));
        check({tag, "_regwrite"}, 32'(RegWrite_o), 32'(!we));
        check({tag, "_bus_err"}, 32'(bus_err_o), 32'd0);
        check({tag, "_addr_o"}, memAddress_o, addr);
        check({tag, "_rd_o"}, 32'(rd_o), 32'd9);
        if (!we) check({tag, "_rdata"}, readData_o, exp_rd);
        idle_inputs();
    endtask

    initial begin
        int s0, r0;
        idle_inputs();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        valid_i = 1'b1; MemRead_i = 1'b1; funct3_i = F3_W; memAddress_i = 32'h2;
        #2;
        check("rst_misalign", 32'(misalign_err_o), 32'd0);
        memAddress_i = 32'h0;
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_rdata", readData_o, 32'd0);
        check("rst_bus_err", 32'(bus_err_o), 32'd0);
        idle_inputs();
        step(); step();
        rstn = 1'b1;

        // non-memory op passes straight through
        step();
        r0 = req_total;
        valid_i = 1'b1; memAddress_i = 32'h0000_1234; rd_i = 5'd5; RegWrite_i = 1'b1; MemtoReg_i = 2'd2;
        #1;
        check("alu_stall", 32'(stall_o), 32'd0);
        check("alu_addr", memAddress_o, 32'h0000_1234);
        check("alu_rd", 32'(rd_o), 32'd5);
        check("alu_regwrite", 32'(RegWrite_o), 32'd1);
        check("alu_memtoreg", 32'(MemtoReg_o), 32'd2);
        step();
        check("alu_stall2", 32'(stall_o), 32'd0);
        check("alu_no_req", 32'(req_total - r0), 32'd0);
        idle_inputs();

        do_access("lb",  1'b0, F3_B,  32'h103, 32'h0,         32'h80FF_1234, 1,  4'b1000, 32'h0,         32'hFFFF_FF80);
        do_access("lhu", 1'b0, F3_HU, 32'h202, 32'h0,         32'hBEEF_0000, 3,  4'b1100, 32'h0,         32'h0000_BEEF);
        do_access("sb",  1'b1, F3_B,  32'h301, 32'h0000_00AB, 32'h0,         3,  4'b0010, 32'hABAB_ABAB, 32'h0);
        do_access("sh",  1'b1, F3_H,  32'h302, 32'h1234_CDEF, 32'h0,         1,  4'b1100, 32'hCDEF_CDEF, 32'h0);
        do_access("sw",  1'b1, F3_W,  32'h500, 32'hCAFE_F00D, 32'h0,         2,  4'b1111, 32'hCAFE_F00D, 32'h0);
        do_access("lh",  1'b0, F3_H,  32'h504, 32'h0,         32'h1234_8001, 1,  4'b0011, 32'h0,         32'hFFFF_8001);
        do_access("lbu", 1'b0, F3_BU, 32'h601, 32'h0,         32'h0000_9A00, 2,  4'b0010, 32'h0,         32'h0000_009A);
        do_access("lw_edge", 1'b0, F3_W, 32'h700, 32'h0,      32'hDEAD_BEEF, 16, 4'b1111, 32'h0,         32'hDEAD_BEEF);

        // misaligned accesses never reach the bus
        step();
        r0 = req_total;
        valid_i = 1'b1; MemRead_i = 1'b1; funct3_i = F3_W; memAddress_i = 32'h402;
        rd_i = 5'd3; RegWrite_i = 1'b1; MemtoReg_i = 2'd1;
        #1;
        check("mis_lw_flag", 32'(misalign_err_o), 32'd1);
        check("mis_lw_stall", 32'(stall_o), 32'd0);
        check("mis_lw_regwrite", 32'(RegWrite_o), 32'd0);
        step();
        funct3_i = F3_H; memAddress_i = 32'h503;
        #1;
        check("mis_lh_flag", 32'(misalign_err_o), 32'd1);
        step();
        idle_inputs();
        #1;
        check("mis_flag_clear", 32'(misalign_err_o), 32'd0);
        step();
        check("mis_no_req", 32'(req_total - r0), 32'd0);

        // timeout: no ready for 16 BUSY cycles
        step();
        s0 = stall_total;
        valid_i = 1'b1; MemRead_i = 1'b1; funct3_i = F3_W; memAddress_i = 32'h900;
        rd_i = 5'd9; RegWrite_i = 1'b1; MemtoReg_i = 2'd1;
        #1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16) begin
                check("to_last_req", 32'(dmem_req), 32'd1);
                check("to_last_stall", 32'(stall_o), 32'd1);
            end
        end
        step();
        check("to_bus_err", 32'(bus_err_o), 32'd1);
        check("to_rdata", readData_o, 32'd0);
        check("to_regwrite", 32'(RegWrite_o), 32'd0);
        check("to_stall", 32'(stall_o), 32'd0);
        check("to_req", 32'(dmem_req), 32'd0);
        check("to_stall_cycles", 32'(stall_total - s0), 32'd17);
        idle_inputs();
        step();
        check("to_err_clear", 32'(bus_err_o), 32'd0);

        // reset while BUSY aborts the access
        step();
        valid_i = 1'b1; MemRead_i = 1'b1; funct3_i = F3_W; memAddress_i = 32'h800; RegWrite_i = 1'b1;
        step();
        check("rb_busy_req", 32'(dmem_req), 32'd1);
        #2 rstn = 1'b0;
        #2;
        check("rb_req_drop", 32'(dmem_req), 32'd0);
        check("rb_stall_low", 32'(stall_o), 32'd0);
        idle_inputs();
        @(posedge clk);
        #3 rstn = 1'b1;
        r0 = req_total;
        step();
        check("rb_idle_stall", 32'(stall_o), 32'd0);
        step(); step();
        check("rb_no_retry", 32'(req_total - r0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
